// File: rtl/regfile_2r1w_pkg.sv
// regfile_2r1w_pkg: shared register-file widths, constants and init-FSM state encoding
package regfile_2r1w_pkg;
  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_REG_NUM = 32;
  typedef logic [RF_DATA_W-1:0] reg_bus_t;
  typedef logic [RF_ADDR_W-1:0] reg_addr_bus_t;
  localparam reg_bus_t ZERO_WORD = '0;
  localparam reg_addr_bus_t NOP_REG_ADDR = '0;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE = 1'b1;
  typedef enum logic {RF_INIT = 1'b0, RF_RUN = 1'b1} rf_state_t;
endpackage

// File: rtl/regfile_2r1w_init_seq.sv
// rf_init_seq: post-reset sweep FSM (clk, rst in; clr_en, clr_addr, rf_ready out), clears entries 1..REG_NUM-1
module rf_init_seq
  import regfile_2r1w_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int REG_NUM = RF_REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              rf_ready
);
  rf_state_t state;
  logic [ADDR_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RF_INIT;
      cnt <= ADDR_W'(1);
      rf_ready <= 1'b0;
    end else if (state == RF_INIT) begin
      if (cnt == ADDR_W'(REG_NUM - 1)) begin
        state <= RF_RUN;
        rf_ready <= 1'b1;
      end else cnt <= cnt + 1'b1;
    end
  assign clr_en = state == RF_INIT;
  assign clr_addr = cnt;
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read/1-write register file with bypass and post-reset clear sweep (we/waddr/wdata write; regN_read/regN_addr -> regN_data; rf_ready, wr_drop status)
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int REG_NUM = RF_REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              reg0_read,
  input  logic [ADDR_W-1:0] reg0_addr,
  output logic [DATA_W-1:0] reg0_data,
  input  logic              reg1_read,
  input  logic [ADDR_W-1:0] reg1_addr,
  output logic [DATA_W-1:0] reg1_data,
  output logic              rf_ready,
  output logic              wr_drop
);
  logic [DATA_W-1:0] mem [REG_NUM];
  logic clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic wr_req;
  rf_init_seq #(.ADDR_W(ADDR_W), .REG_NUM(REG_NUM)) u_init (
    .clk(clk), .rst(rst), .clr_en(clr_en), .clr_addr(clr_addr), .rf_ready(rf_ready)
  );
  assign wr_req = we == WRITE_ENABLE && waddr != ADDR_W'(0);
  always_ff @(posedge clk)
    if (clr_en) mem[clr_addr] <= '0;
    else if (wr_req) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) wr_drop <= 1'b0;
    else wr_drop <= wr_req && clr_en;
  always_comb begin
    reg0_data = (rst || !rf_ready || reg0_read != READ_ENABLE || reg0_addr == ADDR_W'(0)) ? '0 :
                (wr_req && waddr == reg0_addr) ? wdata : mem[reg0_addr];
    reg1_data = (rst || !rf_ready || reg1_read != READ_ENABLE || reg1_addr == ADDR_W'(0)) ? '0 :
                (wr_req && waddr == reg1_addr) ? wdata : mem[reg1_addr];
  end
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed self-checking bench for regfile_2r1w
module tb_regfile_2r1w;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic we = 1'b0;
  logic [4:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic reg0_read = 1'b0;
  logic [4:0] reg0_addr = '0;
  logic [31:0] reg0_data;
  logic reg1_read = 1'b0;
  logic [4:0] reg1_addr = '0;
  logic [31:0] reg1_data;
  logic rf_ready;
  logic wr_drop;
  int pass_cnt = 0;
  int chk_cnt = 0;
  always #5 clk = ~clk;
  regfile_2r1w dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .reg0_read(reg0_read), .reg0_addr(reg0_addr), .reg0_data(reg0_data),
    .reg1_read(reg1_read), .reg1_addr(reg1_addr), .reg1_data(reg1_data),
    .rf_ready(rf_ready), .wr_drop(wr_drop)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    reg0_read = 1'b1;
    reg0_addr = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (rf_ready !== 1'b0 || reg0_data !== 32'h0 || wr_drop !== 1'b0)
      $display("FAIL reset_hold: rf_ready=%b reg0_data=%h wr_drop=%b, want 0/0/0", rf_ready, reg0_data, wr_drop);
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk_cnt++;
      if (rf_ready !== (i == 31) || reg0_data !== 32'h0)
        $display("FAIL reset_sweep edge %0d: rf_ready=%b reg0_data=%h, want %b/0", i, rf_ready, reg0_data, i == 31);
      else pass_cnt++;
    end
    reg0_read = 1'b0;
  endtask
  task automatic test_write_read();
    we = 1'b1;
    waddr = 5'd3;
    wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    reg0_read = 1'b1;
    reg0_addr = 5'd3;
    #1;
    chk_cnt++;
    if (reg0_data !== 32'hDEADBEEF) $display("FAIL readback: got %h want deadbeef", reg0_data);
    else pass_cnt++;
    chk_cnt++;
    if (wr_drop !== 1'b0) $display("FAIL run_no_drop: wr_drop=%b want 0", wr_drop);
    else pass_cnt++;
    reg0_read = 1'b0;
    #1;
    chk_cnt++;
    if (reg0_data !== 32'h0) $display("FAIL read_disabled: got %h want 0", reg0_data);
    else pass_cnt++;
  endtask
  task automatic test_bypass_dual();
    tick();
    we = 1'b1;
    waddr = 5'd7;
    wdata = 32'h12345678;
    reg0_read = 1'b1;
    reg1_read = 1'b1;
    reg0_addr = 5'd7;
    reg1_addr = 5'd7;
    #1;
    chk_cnt++;
    if (reg0_data !== 32'h12345678 || reg1_data !== 32'h12345678)
      $display("FAIL bypass: r0=%h r1=%h want 12345678", reg0_data, reg1_data);
    else pass_cnt++;
    tick();
    we = 1'b0;
    reg1_addr = 5'd3;
    #1;
    chk_cnt++;
    if (reg0_data !== 32'h12345678 || reg1_data !== 32'hDEADBEEF)
      $display("FAIL dual_storage: r0=%h r1=%h want 12345678/deadbeef", reg0_data, reg1_data);
    else pass_cnt++;
    reg0_read = 1'b0;
    reg1_read = 1'b0;
  endtask
  task automatic test_zero_reg();
    tick();
    we = 1'b1;
    waddr = 5'd0;
    wdata = 32'hFFFFFFFF;
    reg0_read = 1'b1;
    reg1_read = 1'b1;
    reg0_addr = 5'd0;
    reg1_addr = 5'd0;
    #1;
    chk_cnt++;
    if (reg0_data !== 32'h0 || reg1_data !== 32'h0) $display("FAIL zero_same: r0=%h r1=%h want 0", reg0_data, reg1_data);
    else pass_cnt++;
    tick();
    we = 1'b0;
    #1;
    chk_cnt++;
    if (reg0_data !== 32'h0 || reg1_data !== 32'h0 || wr_drop !== 1'b0)
      $display("FAIL zero_next: r0=%h r1=%h wr_drop=%b want 0/0/0", reg0_data, reg1_data, wr_drop);
    else pass_cnt++;
    reg0_read = 1'b0;
    reg1_read = 1'b0;
  endtask
  task automatic test_init_write();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    we = 1'b1;
    waddr = 5'd9;
    wdata = 32'hA5A5A5A5;
    reg0_read = 1'b1;
    reg0_addr = 5'd9;
    #1;
    chk_cnt++;
    if (reg0_data !== 32'h0) $display("FAIL init_read: got %h want 0", reg0_data);
    else pass_cnt++;
    tick();
    we = 1'b0;
    chk_cnt++;
    if (wr_drop !== 1'b1) $display("FAIL init_drop: wr_drop=%b want 1", wr_drop);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (wr_drop !== 1'b0) $display("FAIL drop_pulse: wr_drop=%b want 0", wr_drop);
    else pass_cnt++;
    repeat (24) tick();
    chk_cnt++;
    if (rf_ready !== 1'b0) $display("FAIL init_edge30: rf_ready=%b want 0", rf_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (rf_ready !== 1'b1 || reg0_data !== 32'h0)
      $display("FAIL init_done: rf_ready=%b r9=%h want 1/0", rf_ready, reg0_data);
    else pass_cnt++;
    reg0_read = 1'b0;
  endtask
  task automatic test_reset_mid_run();
    we = 1'b1;
    waddr = 5'd4;
    wdata = 32'h1;
    tick();
    we = 1'b0;
    reg0_read = 1'b1;
    reg0_addr = 5'd4;
    #1;
    chk_cnt++;
    if (reg0_data !== 32'h1) $display("FAIL r4_before: got %h want 1", reg0_data);
    else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    chk_cnt++;
    if (rf_ready !== 1'b0 || reg0_data !== 32'h0)
      $display("FAIL async_rst: rf_ready=%b r4=%h want 0/0", rf_ready, reg0_data);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    repeat (30) tick();
    chk_cnt++;
    if (rf_ready !== 1'b0 || reg0_data !== 32'h0)
      $display("FAIL rerun_edge30: rf_ready=%b r4=%h want 0/0", rf_ready, reg0_data);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (rf_ready !== 1'b1 || reg0_data !== 32'h0)
      $display("FAIL rerun_done: rf_ready=%b r4=%h want 1/0", rf_ready, reg0_data);
    else pass_cnt++;
    reg0_read = 1'b0;
  endtask
  initial begin
    #1;
    test_reset();
    test_write_read();
    test_bypass_dual();
    test_zero_reg();
    test_init_write();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- General-purpose register file for the openMIPS pipeline.
- Serves the decode stage's two read requests (reg0/reg1 read-enable plus address) and is written by the write-back stage.
- Reads are combinational, with write-to-read bypass, so decode sees same-cycle data.
- After reset, an internal sweep clears the storage array one entry per cycle so that it maps to RAM-friendly storage; `rf_ready` flags completion.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- REG_NUM, 32, number of architectural registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable from write-back.
- waddr  input  ADDR_W  write register index.
- wdata  input  DATA_W  write data.
- reg0_read  input  1  read-port-0 enable from decode.
- reg0_addr  input  ADDR_W  read-port-0 index.
- reg0_data  output  DATA_W  read-port-0 data, combinational.
- reg1_read  input  1  read-port-1 enable from decode.
- reg1_addr  input  ADDR_W  read-port-1 index.
- reg1_data  output  DATA_W  read-port-1 data, combinational.
- rf_ready  output  1  high once the init sweep is done and normal operation is running.
- wr_drop  output  1  registered pulse, high one cycle after a write is discarded.

Behaviour:
- Reset (async assert): state=INIT, sweep counter=1, rf_ready=0, wr_drop=0.
  - Array contents are not reset by rst.
  - While rst is high, reg0_data=reg1_data=0.
- State INIT:
  - On each rising edge, entry[cnt] is cleared to 0, then cnt increments.
  - When cnt==REG_NUM-1 is cleared, state goes to RUN.
  - rf_ready rises after the 31st rising edge following rst deassertion (default params).
- State RUN:
  - rf_ready=1. RUN has no exit other than rst.
- Reset mid-sweep or mid-run: immediate return to INIT with cnt=1; the sweep restarts from the beginning.
- Entry 0 is hardwired to zero:
  - Never written or read from storage.
  - The sweep starts at 1.
  - A write with waddr==0 is ignored silently (no wr_drop).
- Write, RUN only:
  - If we && waddr!=0, entry[waddr] takes wdata on the rising edge.
  - The new value is visible from storage the following cycle.
- Write during INIT: discarded. wr_drop=1 in the next cycle, else 0.
  - Applies to any we=1 with waddr!=0, including a write whose address collides with the sweep counter; the sweep clear wins.
- Read port p (identical logic for p=0,1), priority order:
  1. rst high, state==INIT, or regp_read==0 -> 0.
  2. regp_addr==0 -> 0.
  3. we && waddr==regp_addr (RUN) -> wdata (bypass; same-cycle write-to-read forwarding).
  4. Otherwise -> entry[regp_addr].
- Both ports may read the same address, including with a simultaneous bypass; both return the same value.
- Latency:
  - Read: 0 cycles (combinational).
  - Write: 1 cycle to storage, 0 cycles via bypass.
- Width rules: no truncation or extension; data is always DATA_W bits.
- Read outputs contain no X: a read of an entry before the sweep completes is impossible because outputs are forced to 0 in INIT.

Decomposition:
- Shared defines file (pipeline-wide):
  - RegBus (DATA_W-1:0), RegAddrBus (ADDR_W-1:0).
  - ZeroWord, WriteEnable/ReadEnable constants.
  - RegNum, NOPRegAddr (0).
  - Init-FSM state encodings RF_INIT/RF_RUN.
- One natural sub-module: `rf_init_seq`, holding the INIT/RUN FSM plus the sweep counter. It outputs clr_en, clr_addr and rf_ready.
- The array, write logic and both read muxes stay in the top module.

Test Plan:
- Reset then idle: assert rst 3 cycles, release -> rf_ready=0 for 30 edges, =1 after edge 31. Read of r5 with reg0_read=1 gives 0 throughout.
- Write/read back after ready: we=1, waddr=3, wdata=32'hDEADBEEF for one cycle. Next cycle reg0_read=1, reg0_addr=3 -> reg0_data=32'hDEADBEEF. The same read with reg0_read=0 gives 0.
- Bypass and dual port: in the same cycle, we=1, waddr=7, wdata=32'h12345678, reg0_addr=reg1_addr=7, both reads enabled -> both outputs equal 32'h12345678 that cycle.
- Zero register: we=1, waddr=0, wdata=32'hFFFFFFFF -> reads of r0 return 0 in the same and following cycles; wr_drop stays 0.
- Write during INIT: 5 cycles after rst release, we=1, waddr=9, wdata=32'hA5A5A5A5 -> wr_drop=1 next cycle. After rf_ready, read r9 gives 0.
- Reset mid-run: r4=32'h1, then assert rst for 1 cycle -> rf_ready=0 immediately and outputs=0. After 31 edges rf_ready=1 and r4 reads 0.
